led_recv: RTL and testbench

//  Receive side of the two-wire LED link (clock + data, 150 MHz system clock).

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_rx_sync_edge.sv | 33 +++
 rtl/led_recv.sv | 183 ++++++++++++++++++
 tb/tb_led_recv.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED link receiver.
package led_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } led_rx_state_t;

  localparam logic [31:0] START_WORD = 32'h0000_0000;
  localparam logic [31:0] END_WORD   = 32'hFFFF_FFFF;
  localparam logic [2:0]  LED_HDR    = 3'b111;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_HDR     = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_OVF     = 2'b11
  } led_err_t;

endpackage

// File: rtl/led_rx_sync_edge.sv
// Brings the async link clock/data into clk and flags each cki rising edge.
// Both lines share the same synchronizer depth so sdi_s lines up with rise.
module led_rx_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic cki,
  input  logic sdi,
  output logic sdi_s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] cki_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   cki_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cki_sync_q <= '0;
      sdi_sync_q <= '0;
      cki_q      <= 1'b0;
    end else begin
      cki_sync_q <= {cki_sync_q[SYNC_STAGES-2:0], cki};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      cki_q      <= cki_sync_q[SYNC_STAGES-1];
    end
  end

  assign rise  = cki_sync_q[SYNC_STAGES-1] & ~cki_q;
  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/led_recv.sv
// LED link receiver: aligns on the all-zero start frame, decodes LED frames
// into FIFO writes until the all-ones end frame; outputs are registered (1 clk).
module led_recv
  import led_pkg::*;
#(
  parameter int MAX_LED     = 1024,
  parameter int CNT_W       = $clog2(MAX_LED + 1),
  parameter int TIMEOUT_CNT = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cki,
  input  logic             sdi,
  input  logic             wfull,
  output logic             wr,
  output logic [23:0]      wdata,
  output logic [4:0]       bright,
  output logic             frame_start,
  output logic             frame_done,
  output logic [CNT_W-1:0] led_cnt,
  output logic             busy,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam int               TO_W    = $clog2(TIMEOUT_CNT + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CNT);
  localparam logic [CNT_W-1:0] LED_MAX = CNT_W'(MAX_LED);

  logic sdi_s, rise;

  led_rx_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .cki   (cki),
    .sdi   (sdi),
    .sdi_s (sdi_s),
    .rise  (rise)
  );

  led_rx_state_t    state_q, state_d;
  // Only 31 bits are stored: the 32nd bit of a word is taken live from sdi_s.
  logic [30:0]      sr_q, sr_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [5:0]       zero_run_q, zero_run_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] led_cnt_q, led_cnt_d;
  logic             wr_q, wr_d;
  logic [23:0]      wdata_q, wdata_d;
  logic [4:0]       bright_q, bright_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;

  logic [31:0] word;
  logic [5:0]  zero_inc;
  logic        timeout;

  always_comb begin
    state_d       = state_q;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    zero_run_d    = zero_run_q;
    to_cnt_d      = to_cnt_q;
    led_cnt_d     = led_cnt_q;
    wr_d          = 1'b0;
    wdata_d       = wdata_q;
    bright_d      = bright_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    word          = {sr_q, sdi_s};
    zero_inc      = zero_run_q + 6'd1;
    timeout       = (to_cnt_q == TO_MAX) && !rise;

    if (rise) begin
      sr_d     = word[30:0];
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (rise) begin
          if (sdi_s) begin
            zero_run_d = '0;
          end else if (zero_inc == 6'd32) begin
            state_d       = RECV;
            bit_cnt_d     = '0;
            led_cnt_d     = '0;
            zero_run_d    = '0;
            frame_start_d = 1'b1;
          end else begin
            zero_run_d = zero_inc;
          end
        end else if (timeout) begin
          zero_run_d = '0;
        end
      end
      RECV: begin
        if (rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) begin
            // End word is tested before the header so all-ones never becomes LED data.
            if (word == START_WORD) begin
              state_d = RECV;
            end else if (word == END_WORD) begin
              frame_done_d = 1'b1;
              state_d      = IDLE;
            end else if (word[31:29] == LED_HDR) begin
              if (!wfull && (led_cnt_q < LED_MAX)) begin
                wr_d      = 1'b1;
                wdata_d   = word[23:0];
                bright_d  = word[28:24];
                led_cnt_d = led_cnt_q + CNT_W'(1);
              end else begin
                err_d      = 1'b1;
                err_code_d = ERR_OVF;
              end
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_HDR;
              state_d    = IDLE;
            end
          end
        end else if (timeout) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          bit_cnt_d  = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      zero_run_q    <= '0;
      to_cnt_q      <= '0;
      led_cnt_q     <= '0;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
      bright_q      <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= '0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      zero_run_q    <= zero_run_d;
      to_cnt_q      <= to_cnt_d;
      led_cnt_q     <= led_cnt_d;
      wr_q          <= wr_d;
      wdata_q       <= wdata_d;
      bright_q      <= bright_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign wr          = wr_q;
  assign wdata       = wdata_q;
  assign bright      = bright_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign led_cnt     = led_cnt_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_led_recv.sv
// Scoreboard bench for led_recv: a word-level model predicts the output events of each image.
`timescale 1ns/1ps
module tb_led_recv;

  localparam int TB_MAX = 8;
  localparam int TB_CW  = $clog2(TB_MAX + 1);
  localparam int EV_START = 0, EV_WR = 1, EV_DONE = 2, EV_ERR = 3;

  typedef struct {
    int          kind;
    logic [23:0] data;
    logic [4:0]  br;
    logic [1:0]  code;
    int          cnt;
  } ev_t;

  logic             clk = 1'b0, rstn = 1'b0, cki = 1'b0, sdi = 1'b0, wfull = 1'b0;
  logic             wr, frame_start, frame_done, busy, err;
  logic [23:0]      wdata;
  logic [4:0]       bright;
  logic [TB_CW-1:0] led_cnt;
  logic [1:0]       err_code;

  int checks = 0, passes = 0;
  int m_cnt = 0;
  ev_t exp_q[$];
  logic [31:0] img_w[$];
  bit          img_f[$];

  led_recv #(.MAX_LED(TB_MAX)) dut (
    .clk(clk), .rstn(rstn), .cki(cki), .sdi(sdi), .wfull(wfull),
    .wr(wr), .wdata(wdata), .bright(bright), .frame_start(frame_start),
    .frame_done(frame_done), .led_cnt(led_cnt), .busy(busy), .err(err),
    .err_code(err_code)
  );

  always #3.333 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic push_ev(input int kind, input logic [23:0] d, input logic [4:0] b,
                         input logic [1:0] c, input int n);
    ev_t e;
    e.kind = kind; e.data = d; e.br = b; e.code = c; e.cnt = n;
    exp_q.push_back(e);
  endtask

  // Word-level reference: what each received word should produce.
  task automatic model_word(input logic [31:0] w, input bit full, output bit ends);
    ends = 1'b0;
    if (w == 32'h0) begin
      ends = 1'b0;
    end else if (w == 32'hFFFF_FFFF) begin
      push_ev(EV_DONE, 24'h0, 5'h0, 2'b00, m_cnt);
      ends = 1'b1;
    end else if (w[31:29] == 3'b111) begin
      if (!full && m_cnt < TB_MAX) begin
        m_cnt++;
        push_ev(EV_WR, w[23:0], w[28:24], 2'b00, m_cnt);
      end else begin
        push_ev(EV_ERR, 24'h0, 5'h0, 2'b11, m_cnt);
      end
    end else begin
      push_ev(EV_ERR, 24'h0, 5'h0, 2'b01, m_cnt);
      ends = 1'b1;
    end
  endtask

  task automatic send_bit(input logic b);
    int lo, hi;
    lo = $urandom_range(3, 4);
    hi = $urandom_range(3, 4);
    cki = 1'b0;
    sdi = b;
    repeat (lo) @(posedge clk);
    #1 cki = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit full);
    wfull = full;
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_start();
    m_cnt = 0;
    push_ev(EV_START, 24'h0, 5'h0, 2'b00, 0);
    send_word(32'h0, 1'b0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic run_image(input string name);
    bit ends;
    send_start();
    foreach (img_w[i]) begin
      model_word(img_w[i], img_f[i], ends);
      send_word(img_w[i], img_f[i]);
      if (ends) break;
    end
    wfull = 1'b0;
    drain(name);
    img_w.delete();
    img_f.delete();
  endtask

  task automatic pop_check(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got kind %0d with nothing expected", kind);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind == kind) begin
        if (kind == EV_WR) begin
          chk("wdata", wdata, e.data);
          chk("bright", bright, e.br);
          chk("led_cnt_wr", led_cnt, e.cnt);
        end else if (kind == EV_DONE) begin
          chk("led_cnt_done", led_cnt, e.cnt);
        end else if (kind == EV_ERR) begin
          chk("err_code", err_code, e.code);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (frame_start) pop_check(EV_START);
      if (wr || err || frame_done) begin
        chk("one_pulse", 32'(wr) + 32'(err) + 32'(frame_done), 1);
        if (wr) pop_check(EV_WR);
        else if (err) pop_check(EV_ERR);
        else pop_check(EV_DONE);
      end
    end
  end

  initial begin
    logic [31:0] w;
    int n;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_wr", wr, 0);           chk("rst_wdata", wdata, 0);
    chk("rst_led_cnt", led_cnt, 0); chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);         chk("rst_err_code", err_code, 0);
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 4 LEDs then end
    img_w = '{32'hFF11_2233, 32'hFF22_3344, 32'hFF33_4455, 32'hFF44_5566, 32'hFFFF_FFFF};
    img_f = '{0, 0, 0, 0, 0};
    run_image("img_basic");
    chk("led_cnt_hold", led_cnt, 4);
    chk("busy_after_done", busy, 0);

    // extra start words ignored
    img_w = '{32'h0, 32'h0, 32'hE5AB_CDEF, 32'hFFFF_FFFF};
    img_f = '{0, 0, 0, 0};
    run_image("img_extra_zero");

    // bad header, then a good image
    img_w = '{32'h5A00_0000};
    img_f = '{0};
    run_image("img_bad_hdr");
    chk("busy_after_hdr_err", busy, 0);
    img_w = '{32'hE012_3456, 32'hFFFF_FFFF};
    img_f = '{0, 0};
    run_image("img_after_hdr");

    // FIFO full during the 2nd LED
    img_w = '{32'hF0AA_BBCC, 32'hF1DD_EEFF, 32'hF200_1122, 32'hFFFF_FFFF};
    img_f = '{0, 1, 0, 0};
    run_image("img_wfull");

    // more LEDs than MAX_LED
    for (int i = 0; i < TB_MAX + 1; i++) begin
      img_w.push_back({3'b111, 5'(i), 24'($urandom)});
      img_f.push_back(1'b0);
    end
    img_w.push_back(32'hFFFF_FFFF);
    img_f.push_back(1'b0);
    run_image("img_max_led");

    // cki stalls after 10 bits of the first LED
    send_start();
    w = 32'hFF12_3456;
    for (int i = 31; i > 21; i--) send_bit(w[i]);
    chk("busy_in_recv", busy, 1);
    push_ev(EV_ERR, 24'h0, 5'h0, 2'b10, 0);
    drain("img_timeout");
    chk("busy_after_timeout", busy, 0);
    img_w = '{32'hE7C0_FFEE, 32'hFFFF_FFFF};
    img_f = '{0, 0};
    run_image("img_after_timeout");

    // reset in the middle of an LED word
    send_start();
    w = 32'hFF98_7654;
    for (int i = 31; i > 19; i--) send_bit(w[i]);
    chk("start_consumed", exp_q.size(), 0);
    exp_q.delete();
    rstn = 1'b0;
    cki  = 1'b0;
    #1;
    chk("rstmid_wr", wr, 0);           chk("rstmid_wdata", wdata, 0);
    chk("rstmid_bright", bright, 0);   chk("rstmid_busy", busy, 0);
    chk("rstmid_err_code", err_code, 0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    img_w = '{32'hFFFF_FFFF};
    img_f = '{0};
    run_image("img_after_reset");
    chk("led_cnt_after_reset", led_cnt, 0);

    // random images
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 99) < 12) w = 32'h0;
        else begin
          w = {3'b111, 29'($urandom)};
          if (w == 32'hFFFF_FFFF) w[0] = 1'b0;
        end
        img_w.push_back(w);
        img_f.push_back($urandom_range(0, 99) < 15);
      end
      if ($urandom_range(0, 99) < 15) img_w.push_back({3'($urandom_range(1, 6)), 29'($urandom)});
      else img_w.push_back(32'hFFFF_FFFF);
      img_f.push_back(1'b0);
      run_image("img_random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
